// File: rtl/alu_issue_ctrl_if.sv
// Bundles the three buses around the ALU issue controller:
//   cmd_* : upstream command handshake (valid/ready) with sel/op1/op2 payload
//   alu_* : drive to and results from the shared combinational ALU
//   rsp_* : result handshake (valid/ready) with captured result and flags
//   busy_o, op_count_o : status outputs
// The slave modport is the controller's view; master is the view of the
// surrounding logic (sequencer, ALU and result consumer).
interface alu_issue_ctrl_if #(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 8
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_sel_i;
    logic [DWIDTH-1:0] cmd_op1_i;
    logic [DWIDTH-1:0] cmd_op2_i;
    logic [1:0]        alu_sel_o;
    logic [DWIDTH-1:0] alu_op1_o;
    logic [DWIDTH-1:0] alu_op2_o;
    logic [DWIDTH-1:0] alu_res_i;
    logic              alu_zero_i;
    logic              alu_neg_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DWIDTH-1:0] rsp_res_o;
    logic              rsp_zero_o;
    logic              rsp_neg_o;
    logic              busy_o;
    logic [CWIDTH-1:0] op_count_o;

    modport slave (
        input  cmd_valid_i, cmd_sel_i, cmd_op1_i, cmd_op2_i,
        input  alu_res_i, alu_zero_i, alu_neg_i, rsp_ready_i,
        output cmd_ready_o, alu_sel_o, alu_op1_o, alu_op2_o,
        output rsp_valid_o, rsp_res_o, rsp_zero_o, rsp_neg_o,
        output busy_o, op_count_o
    );

    modport master (
        output cmd_valid_i, cmd_sel_i, cmd_op1_i, cmd_op2_i,
        output alu_res_i, alu_zero_i, alu_neg_i, rsp_ready_i,
        input  cmd_ready_o, alu_sel_o, alu_op1_o, alu_op2_o,
        input  rsp_valid_o, rsp_res_o, rsp_zero_o, rsp_neg_o,
        input  busy_o, op_count_o
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for a shared combinational ALU.
// Commands enter a DEPTH-entry FIFO through a valid/ready handshake, are
// issued to the ALU one at a time, and each registered result (with the
// ALU's zero/neg flags, passed through untouched) is returned in command
// order through a second valid/ready handshake.
// Ports:
//   clk_i : clock, all state updates on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : alu_issue_ctrl_if.slave (cmd_*, alu_*, rsp_*, busy_o, op_count_o)
module alu_issue_ctrl #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int CWIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_issue_ctrl_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [1:0]  SEL_ADD    = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Command FIFO storage and bookkeeping
    logic [1:0]        mem_sel [DEPTH];
    logic [DWIDTH-1:0] mem_op1 [DEPTH];
    logic [DWIDTH-1:0] mem_op2 [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Controller registers
    state_t            state;
    logic [1:0]        alu_sel;
    logic [DWIDTH-1:0] alu_op1;
    logic [DWIDTH-1:0] alu_op2;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_res;
    logic              rsp_zero;
    logic              rsp_neg;
    logic [CWIDTH-1:0] op_count;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = bus.cmd_valid_i && !full;

    // Pop happens only when the FSM issues: from IDLE, or back-to-back from
    // RESP on the same edge as the response handshake.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            RESP:    pop = bus.rsp_ready_i && !empty;
            default: pop = 1'b0;
        endcase
    end

    // FIFO payload write; contents need no reset because pointers gate them
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_sel[wr_ptr] <= bus.cmd_sel_i;
            mem_op1[wr_ptr] <= bus.cmd_op1_i;
            mem_op2[wr_ptr] <= bus.cmd_op2_i;
        end
    end

    // FIFO pointers (wrap naturally since DEPTH is a power of two) and count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue/capture/respond FSM with all of its outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            alu_sel   <= SEL_ADD;
            alu_op1   <= '0;
            alu_op2   <= '0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
            op_count  <= '0;
        end else begin
            // Operands to the ALU only ever change on an issue edge
            if (pop) begin
                alu_sel <= mem_sel[rd_ptr];
                alu_op1 <= mem_op1[rd_ptr];
                alu_op2 <= mem_op2[rd_ptr];
            end
            case (state)
                IDLE: begin
                    state <= pop ? EXEC : IDLE;
                end
                EXEC: begin
                    rsp_res   <= bus.alu_res_i;
                    rsp_zero  <= bus.alu_zero_i;
                    rsp_neg   <= bus.alu_neg_i;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        op_count  <= op_count + CWIDTH'(1);
                        rsp_valid <= 1'b0;
                        state     <= pop ? EXEC : IDLE;
                    end else begin
                        state <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = !full;
    assign bus.busy_o      = (state != IDLE) || !empty;
    assign bus.alu_sel_o   = alu_sel;
    assign bus.alu_op1_o   = alu_op1;
    assign bus.alu_op2_o   = alu_op2;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_res_o   = rsp_res;
    assign bus.rsp_zero_o  = rsp_zero;
    assign bus.rsp_neg_o   = rsp_neg;
    assign bus.op_count_o  = op_count;

endmodule
